// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU and jump encodings, field widths and the ID/EX record
// shared by the execute/writeback stage.
package cpu_pkg;
    localparam int XLEN  = 32;
    localparam int PC_W  = 5;
    localparam int REG_W = 5;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [3:0] JT_NONE = 4'd0;
    localparam logic [3:0] JT_JAL  = 4'd1;
    localparam logic [3:0] JT_JALR = 4'd2;
    localparam logic [3:0] JT_BEQ  = 4'd3;
    localparam logic [3:0] JT_BNE  = 4'd4;
    localparam logic [3:0] JT_BLT  = 4'd5;
    localparam logic [3:0] JT_BGE  = 4'd6;
    localparam logic [3:0] JT_BLTU = 4'd7;
    localparam logic [3:0] JT_BGEU = 4'd8;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd;
        logic             rd_we;
        logic [3:0]       jump_type;
        logic             mem_we;
        logic             mem_to_reg;
        logic             alu_src;
        logic [4:0]       alu_op;
        logic [PC_W-1:0]  pc;
    } idex_t;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU, branch comparator and jump target / link generation.
module exec_alu
    import cpu_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] cmp_b,
    input  logic [XLEN-1:0] imm,
    input  logic [PC_W-1:0] pc,
    input  logic [4:0]      alu_op,
    input  logic [3:0]      jump_type,
    output logic [XLEN-1:0] result,
    output logic [AW-1:0]   mem_addr,
    output logic            taken,
    output logic [PC_W-1:0] target
);
    logic [XLEN-1:0] alu_result;
    logic [PC_W-1:0] link;
    logic            is_link;

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SLL:   alu_result = op_a << op_b[4:0];
            ALU_SRL:   alu_result = op_a >> op_b[4:0];
            ALU_SRA:   alu_result = $signed(op_a) >>> op_b[4:0];
            ALU_SLT:   alu_result = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU:  alu_result = XLEN'(op_a < op_b);
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    // Branches always compare rs1 against rs2, independent of alu_src
    always_comb begin
        case (jump_type)
            JT_NONE:         taken = 1'b0;
            JT_JAL, JT_JALR: taken = 1'b1;
            JT_BEQ:          taken = op_a == cmp_b;
            JT_BNE:          taken = op_a != cmp_b;
            JT_BLT:          taken = $signed(op_a) < $signed(cmp_b);
            JT_BGE:          taken = $signed(op_a) >= $signed(cmp_b);
            JT_BLTU:         taken = op_a < cmp_b;
            JT_BGEU:         taken = op_a >= cmp_b;
            default:         taken = 1'b0;
        endcase
    end

    assign is_link  = jump_type == JT_JAL || jump_type == JT_JALR;
    assign link     = pc + PC_W'(1);
    assign target   = jump_type == JT_JALR ? op_a[PC_W-1:0] + imm[PC_W-1:0] : pc + imm[PC_W-1:0];
    assign result   = is_link ? XLEN'(link) : alu_result;
    assign mem_addr = alu_result[AW-1:0];
endmodule

// File: rtl/execute_writeback.sv
// execute_writeback: ID/EX and EX/WB registers, data memory and fetch redirect.
// Define EXWB_FORWARD_EN to bypass EX/WB write data into a back-to-back dependent operand.
module execute_writeback
    import cpu_pkg::*;
#(
    parameter int DMEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   read_data1,
    input  logic [XLEN-1:0]   read_data2,
    input  logic [REG_W-1:0]  rs1_addr,
    input  logic [REG_W-1:0]  rs2_addr,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic              in_reg_wrenable,
    input  logic [3:0]        jump_type,
    input  logic              mem_wrenable,
    input  logic              mem_to_reg,
    input  logic              alu_src,
    input  logic [4:0]        alu_op,
    input  logic [PC_W-1:0]   pc,
    output logic [REG_W-1:0]  write_reg,
    output logic [XLEN-1:0]   write_data,
    output logic              reg_wrenable,
    output logic              should_jump,
    output logic [PC_W-1:0]   jump_pc
);
    localparam int AW = $clog2(DMEM_WORDS);

    idex_t            idex_q, idex_d;
    logic [REG_W-1:0] write_reg_q, write_reg_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;
    logic             reg_wrenable_q, reg_wrenable_d;
    logic [XLEN-1:0]  op_a, op_b, rs2_val, result, dmem_rdata;
    logic [AW-1:0]    dmem_addr;
    logic             taken;
    logic [XLEN-1:0]  dmem [DMEM_WORDS];

`ifdef EXWB_FORWARD_EN
    logic [REG_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
    always_comb begin
        rs1_addr_d = should_jump ? '0 : rs1_addr;
        rs2_addr_d = should_jump ? '0 : rs2_addr;
        op_a = reg_wrenable_q && write_reg_q != '0 && write_reg_q == rs1_addr_q ? write_data_q : idex_q.rs1_val;
        rs2_val = reg_wrenable_q && write_reg_q != '0 && write_reg_q == rs2_addr_q ? write_data_q : idex_q.rs2_val;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
        end else begin
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
        end
    end
`else
    logic unused_rs_addr;
    assign unused_rs_addr = ^{rs1_addr, rs2_addr};
    assign op_a    = idex_q.rs1_val;
    assign rs2_val = idex_q.rs2_val;
`endif

    assign op_b = idex_q.alu_src ? idex_q.imm : rs2_val;

    exec_alu #(.AW(AW)) u_alu (
        .op_a      (op_a),
        .op_b      (op_b),
        .cmp_b     (rs2_val),
        .imm       (idex_q.imm),
        .pc        (idex_q.pc),
        .alu_op    (idex_q.alu_op),
        .jump_type (idex_q.jump_type),
        .result    (result),
        .mem_addr  (dmem_addr),
        .taken     (taken),
        .target    (jump_pc)
    );

    assign should_jump = idex_q.valid && taken;
    assign dmem_rdata  = dmem[dmem_addr];

    // A taken jump in EX turns the wrong-path decode slot into an all-zero bubble
    always_comb begin
        idex_d = should_jump ? '0 : '{
            valid: 1'b1, rs1_val: read_data1, rs2_val: read_data2, imm: imm,
            rd: in_write_reg, rd_we: in_reg_wrenable, jump_type: jump_type,
            mem_we: mem_wrenable, mem_to_reg: mem_to_reg, alu_src: alu_src,
            alu_op: alu_op, pc: pc};
        write_reg_d    = idex_q.rd;
        write_data_d   = idex_q.mem_to_reg ? dmem_rdata : result;
        reg_wrenable_d = idex_q.valid && idex_q.rd_we && idex_q.rd != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q         <= '0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            reg_wrenable_q <= 1'b0;
        end else begin
            idex_q         <= idex_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            reg_wrenable_q <= reg_wrenable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (idex_q.valid && idex_q.mem_we) dmem[dmem_addr] <= rs2_val;
    end

    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign reg_wrenable = reg_wrenable_q;
endmodule

// File: doc/execute_writeback.md
# execute_writeback

Back half of the two-stage-plus-writeback CPU pipeline: consumes the operands and control flags produced by `fetch_decode`, executes the ALU operation, resolves jumps and branches, and accesses a 32-word data memory. It drives the register-file write port (`write_reg`, `write_data`, `reg_wrenable`) and the PC redirect (`should_jump`, `jump_pc`) back into fetch/decode, closing the loop. Internally it holds an ID/EX register and an EX/WB register, plus optional operand forwarding.

## Interface
Parameters:
- `DMEM_WORDS`, 32: data memory depth. It is word-indexed by `alu_result[4:0]`.

Ports:
- `clk`  in  1  pipeline clock; every register updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read_data1`, `read_data2`  in  32  rs1/rs2 operand values from the regfile.
- `rs1_addr`, `rs2_addr`  in  5  rs1/rs2 indices (instr[19:15], instr[24:20]); used for forwarding.
- `imm`  in  32  sign-extended immediate.
- `in_write_reg`  in  5  destination register index.
- `in_reg_wrenable`  in  1  instruction writes rd.
- `jump_type`  in  4  jump/branch class (`cpu_pkg`).
- `mem_wrenable`, `mem_to_reg`, `alu_src`  in  1  store / load-result select / use imm as ALU operand B.
- `alu_op`  in  5  ALU operation (`cpu_pkg`).
- `pc`  in  5  PC of the instruction currently in decode.
- `write_reg`  out  5  regfile write index.
- `write_data`  out  32  regfile write data.
- `reg_wrenable`  out  1  regfile write enable.
- `should_jump`  out  1  redirect fetch this cycle.
- `jump_pc`  out  5  redirect target.

## Operation
- ID/EX register: on each edge it captures all decode inputs plus `valid=1`. It captures a bubble (`valid=0`) instead when `should_jump` is high in that cycle, which flushes the wrong-path instruction.
- Operand A: rs1 value. Operand B: `alu_src ? imm : rs2`. Store data is the rs2 value.
- Forwarding (when compiled in): if EX/WB `reg_wrenable`, `write_reg != 0`, and `write_reg == rsN_addr` held in ID/EX, substitute EX/WB `write_data` for that operand. The regfile is write-through for a same-cycle read/write, so this is the only bypass required.
- ALU ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10.
  - Shifts use `B[4:0]`.
  - Undefined codes produce 0.
  - All arithmetic is 32-bit modulo.
- Jump types: NONE=0, JAL=1, JALR=2, BEQ=3, BNE=4, BLT=5, BGE=6, BLTU=7, BGEU=8. Undefined codes mean no jump.
  - Branches compare forwarded rs1 against forwarded rs2, never against imm.
  - JAL and branch target: `(pc + imm[4:0])` mod 32.
  - JALR target: `(rs1 + imm)[4:0]`.
  - JAL/JALR result is the link value `pc + 1`, zero-extended to 32 bits.
- `should_jump = valid && taken`.
- Data memory:
  - Combinational read at `alu_result[4:0]`.
  - Synchronous write at the edge when `valid && mem_wrenable`.
  - Not reset; contents are X until written.
- EX/WB register captures:
  - `write_reg <= in_write_reg`
  - `write_data <= mem_to_reg ? dmem_rdata : result`
  - `reg_wrenable <= valid && in_reg_wrenable && (in_write_reg != 0)`

## Timing
- Reset values:
  - ID/EX `valid` = 0 and all ID/EX fields = 0.
  - `write_reg` = 0, `write_data` = 0, `reg_wrenable` = 0.
  - `should_jump` = 0 and `jump_pc` = 0, because both are combinational from the cleared ID/EX register.
- Latency:
  - Decode to EX: 1 cycle.
  - EX to regfile write: 1 cycle.
  - A dependent instruction issued back-to-back gets the correct value via forwarding, including a load result.
- Taken jump costs 1 bubble. `should_jump` is high for exactly one cycle per taken jump; the next cycle is a bubble, so the bubble cannot re-trigger a jump.
- A store in EX writes memory at the same edge that a load of the same address is captured into EX/WB. The load sees the old data; write-first is not required.
- `rst_n` asserted mid-operation:
  - Immediately clears `valid`, `should_jump`, and `reg_wrenable`.
  - An in-flight store is dropped if reset is asserted before its edge.

## Configuration
- `EXWB_FORWARD_EN` defined: forwarding muxes are present as described above.
- `EXWB_FORWARD_EN` undefined:
  - Operands come straight from ID/EX.
  - `rs1_addr`/`rs2_addr` are unused.
  - Software must separate a dependent instruction from its producer by at least one instruction.

## Structure
- `cpu_pkg` holds:
  - the `alu_op` and `jump_type` encodings as localparams;
  - the ID/EX field widths (`PC_W=5`, `REG_W=5`, `XLEN=32`).
- Sub-module `exec_alu`: combinational ALU plus branch comparator. It returns `result` and `taken`.
- `execute_writeback` holds the pipeline registers, forwarding, and data memory.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `reg_wrenable`=0, `should_jump`=0, `write_data`=0. Release reset -> the first valid ADD appears two edges after it is presented at decode.
- ADD x3 = x1(5) + x2(7), then SUB x4 = x3 - imm 2 (`alu_src`=1), back-to-back -> `write_data` 12, then 10 (10 requires the forward).
- Store 0xDEADBEEF to word 9, then load word 9 into x5 -> `write_data` 0xDEADBEEF with `reg_wrenable`=1. The load-to-dependent ADD x6 = x5 + x5 gives 0xBD5B7DDE.
- BEQ at `pc`=4 with equal operands, imm=6 -> `should_jump`=1 and `jump_pc`=10 for one cycle. The next instruction produces no write and no store. JAL at `pc`=31, imm=2 -> `jump_pc`=1 (wrap), link=0.
- Write to x0 with `in_reg_wrenable`=1 -> `reg_wrenable`=0. BLTU with rs1=0xFFFFFFFF, rs2=1 -> not taken. BLT with the same operands -> taken.
- Assert `rst_n` low in the same cycle a taken JALR is in EX -> `should_jump` drops immediately and no redirect or regfile write occurs.
